// File: rtl/rx_ctrl_pkg.sv
// Shared types and default parameters for the receive-side byte controller.
package rx_ctrl_pkg;

  typedef enum logic [1:0] {
    C_SYNC = 2'd0,
    C_IDLE = 2'd1,
    C_RECV = 2'd2,
    C_PUSH = 2'd3
  } capState_t;

  localparam int DEF_FIFO_DEPTH  = 4;
  localparam int DEF_MIN_LOW     = 32;
  localparam int DEF_TIMEOUT_CYC = 160;

endpackage

// File: rtl/rx_byte_fifo.sv
// Byte FIFO with registered occupancy; full+push+pop and empty+pop are resolved here.
module rx_byte_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_l,
  input  logic          push,
  input  logic [7:0]    wrData,
  input  logic          pop,
  output logic [7:0]    rdData,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [DEPTH-1:0][7:0] mem;
  logic [AW-1:0]         wrPtr, rdPtr;
  logic                  doPush, doPop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  // a push into a full FIFO only lands when the head leaves in the same cycle
  assign doPush = push & (~full | pop);
  assign doPop  = pop & ~empty;
  assign rdData = mem[rdPtr];

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      mem   <= '0;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= wrData;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (doPop) rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/rx_byte_ctrl.sv
// Turns the receiver ready level into byte captures, buffers them for the host.
// Optional idle-timeout pulse enabled by defining RX_IDLE_TIMEOUT_EN.
module rx_byte_ctrl
  import rx_ctrl_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int MIN_LOW     = DEF_MIN_LOW,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          sys_clk,
  input  logic          sys_rst_l,
  input  logic [7:0]    rec_dataH,
  input  logic          rec_readyH,
  output logic [7:0]    host_dataH,
  output logic          host_validH,
  input  logic          host_takeH,
  output logic [CW-1:0] fifo_countH,
  output logic          overrunH,
  input  logic          clr_overrunH,
  output logic          rx_idleH
);

  localparam int LW = $clog2(MIN_LOW + 1);

  capState_t     state, stateNxt;
  logic [LW-1:0] lowCnt;
  logic          pushReq, popReq, fifoFull, fifoEmpty;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) state <= C_SYNC;
    else            state <= stateNxt;
  end

  always_comb begin
    stateNxt = state;
    case (state)
      C_SYNC: if (rec_readyH) stateNxt = C_IDLE;
      C_IDLE: if (!rec_readyH) stateNxt = C_RECV;
      C_RECV: if (rec_readyH)
                stateNxt = (lowCnt >= LW'(MIN_LOW - 1)) ? C_PUSH : C_IDLE;
      C_PUSH: stateNxt = C_IDLE;
      default: stateNxt = C_SYNC;
    endcase
  end

  // low cycles seen after the one that left C_IDLE
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      lowCnt <= '0;
    end else if (state == C_IDLE && !rec_readyH) begin
      lowCnt <= '0;
    end else if (state == C_RECV && !rec_readyH && lowCnt != LW'(MIN_LOW)) begin
      lowCnt <= lowCnt + LW'(1);
    end
  end

  assign pushReq     = (state == C_PUSH);
  assign popReq      = host_takeH & host_validH;
  assign host_validH = ~fifoEmpty;

  rx_byte_fifo #(.DEPTH(FIFO_DEPTH)) uFifo (
    .sys_clk   (sys_clk),
    .sys_rst_l (sys_rst_l),
    .push      (pushReq),
    .wrData    (rec_dataH),
    .pop       (popReq),
    .rdData    (host_dataH),
    .count     (fifo_countH),
    .full      (fifoFull),
    .empty     (fifoEmpty)
  );

  // a drop in the same cycle as a clear keeps the flag set
  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l)                     overrunH <= 1'b0;
    else if (pushReq & fifoFull & ~popReq) overrunH <= 1'b1;
    else if (clr_overrunH)              overrunH <= 1'b0;
  end

`ifdef RX_IDLE_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYC + 1);

  logic [IW-1:0] idleCnt;
  logic          idlePulse;

  always_ff @(posedge sys_clk or negedge sys_rst_l) begin
    if (!sys_rst_l) begin
      idleCnt   <= '0;
      idlePulse <= 1'b0;
    end else begin
      idlePulse <= 1'b0;
      if (pushReq || fifo_countH == '0) begin
        idleCnt <= '0;
      end else if (idleCnt != IW'(TIMEOUT_CYC)) begin
        idleCnt   <= idleCnt + IW'(1);
        idlePulse <= (idleCnt == IW'(TIMEOUT_CYC - 1));
      end
    end
  end

  assign rx_idleH = idlePulse;
`else
  // constant 0; referencing the parameter keeps one interface for both builds
  assign rx_idleH = (TIMEOUT_CYC < 0);
`endif

endmodule
